muldiv_unit: RTL and testbench

//  Iterative 16-bit unsigned multiply/divide unit downstream of the register file.
//  - Consumes the two register read ports: ReadData1 -> OperandA, ReadData2 -> OperandB.
//  - Produces a result plus destination register that the writeback mux presents to the

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative unsigned multiply/divide unit. One result bit per
//                clock: shift-add multiply into a 2*WIDTH product register,
//                restoring shift-subtract divide. Sits between the register
//                file read ports and the writeback mux.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [3:0]       DestReg,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ResultReg,
  output logic             DivByZero
);

  localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);
  localparam logic [1:0]      OP_MULLO  = 2'b00;
  localparam logic [1:0]      OP_MULHI  = 2'b01;
  localparam logic [1:0]      OP_DIVU   = 2'b10;
  localparam logic [1:0]      OP_REMU   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic                 accept;
  logic                 last_step;

  logic [CW-1:0]        cnt;
  logic [1:0]           op_q;
  logic [3:0]           dest_q;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     divisor;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;
  logic [WIDTH-1:0]     sel_result;

  // State register; reset wins over any pending request.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, accept qualification and status outputs.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        Busy = 1'b1;
        if (cnt == LAST_ITER) begin
          last_step  = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        Done = 1'b1;
        if (Start) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // One iteration of both datapaths; the captured Op only picks the result.
  // With a zero divisor every trial subtract succeeds, which naturally yields
  // an all-ones quotient and leaves the dividend as the remainder.
  always_comb begin
    mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next  = {mul_sum, prod[WIDTH-1:1]};
    div_shift  = {rem, quo[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, divisor});
    div_diff   = div_shift[WIDTH-1:0] - divisor;
    rem_next   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    quo_next   = {quo[WIDTH-2:0], div_ge};
    sel_result = '0;
    case (op_q)
      OP_MULLO: sel_result = prod_next[WIDTH-1:0];
      OP_MULHI: sel_result = prod_next[2*WIDTH-1:WIDTH];
      OP_DIVU:  sel_result = quo_next;
      OP_REMU:  sel_result = rem_next;
      default:  sel_result = '0;
    endcase
  end

  // Operand capture at accept, iteration while running, result load on the
  // final iteration edge; results stay put until the next completion.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt       <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      mcand     <= '0;
      divisor   <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      Result    <= '0;
      ResultReg <= '0;
      DivByZero <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= Op;
      dest_q  <= DestReg;
      mcand   <= OperandA;
      divisor <= OperandB;
      prod    <= {{WIDTH{1'b0}}, OperandB};
      rem     <= '0;
      quo     <= OperandA;
    end else if (state == ST_RUN) begin
      cnt  <= last_step ? '0 : cnt + CW'(1);
      prod <= prod_next;
      rem  <= rem_next;
      quo  <= quo_next;
      if (last_step) begin
        Result    <= sel_result;
        ResultReg <= dest_q;
        DivByZero <= op_q[1] && (divisor == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: directed vector table,
//                hand-written reset/interference/back-to-back sequences and
//                randomized operations against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int WIDTH = 16;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic [3:0]       DestReg;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ResultReg;
  logic             DivByZero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .DestReg   (DestReg),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result),
    .ResultReg (ResultReg),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dest;
    logic [15:0] exp_res;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: plain unsigned arithmetic; returns {div_by_zero, result}.
  function automatic logic [16:0] ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      2'b00:   return {1'b0, p[15:0]};
      2'b01:   return {1'b0, p[31:16]};
      2'b10:   return (b == 16'h0) ? {1'b1, 16'hFFFF} : {1'b0, a / b};
      default: return (b == 16'h0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] dest);
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    DestReg  = dest;
  endtask

  // Counts negedges from the issuing negedge until Done; scrambles inputs after
  // the accept edge, and optionally re-raises Start with junk while busy.
  task automatic wait_done(input bit poke, output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge Clk);
      lat++;
      if (lat == 1 || (poke && lat >= 4 && lat <= 8)) begin
        Op       = 2'($urandom);
        OperandA = 16'($urandom);
        OperandB = 16'($urandom);
        DestReg  = 4'($urandom);
      end
      if (lat == 1) Start = 1'b0;
      if (poke && lat == 4) Start = 1'b1;
      if (poke && lat == 9) Start = 1'b0;
      if (Done !== 1'b1 && Busy !== 1'b1) busy_ok = 1'b0;
      if (Done === 1'b1 && Busy !== 1'b0) busy_ok = 1'b0;
    end while (Done !== 1'b1 && lat < 60);
  endtask

  task automatic run_and_check(input string name, input logic [1:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [3:0] dest,
                               input logic [15:0] exp_res, input logic exp_dbz,
                               input bit poke, input int gap);
    int lat;
    bit busy_ok;
    issue(op, a, b, dest);
    wait_done(poke, lat, busy_ok);
    check({name, " latency"}, 32'(lat), 32'd17);
    check({name, " busy"}, {31'h0, busy_ok}, 32'd1);
    check({name, " result"}, {16'h0, Result}, {16'h0, exp_res});
    check({name, " dbz"}, {31'h0, DivByZero}, {31'h0, exp_dbz});
    check({name, " resreg"}, {28'h0, ResultReg}, {28'h0, dest});
    for (int g = 0; g < gap; g++) begin
      @(negedge Clk);
      check({name, " hold"}, {14'h0, Done, Busy, Result}, {16'h0, exp_res});
    end
  endtask

  initial begin
    int          lat;
    bit          busy_ok;
    bit          saw_done;
    logic [1:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  rd;
    logic [16:0] exp;

    vecs[0] = '{2'b00, 16'h1234, 16'h0010, 4'd3,  16'h2340, 1'b0};
    vecs[1] = '{2'b01, 16'hFFFF, 16'hFFFF, 4'd4,  16'hFFFE, 1'b0};
    vecs[2] = '{2'b00, 16'hFFFF, 16'hFFFF, 4'd5,  16'h0001, 1'b0};
    vecs[3] = '{2'b10, 16'd100,  16'd7,    4'd6,  16'h000E, 1'b0};
    vecs[4] = '{2'b11, 16'd100,  16'd7,    4'd7,  16'h0002, 1'b0};
    vecs[5] = '{2'b10, 16'h0005, 16'h0000, 4'd8,  16'hFFFF, 1'b1};
    vecs[6] = '{2'b11, 16'h0005, 16'h0000, 4'd9,  16'h0005, 1'b1};
    vecs[7] = '{2'b01, 16'h8000, 16'h0004, 4'd0,  16'h0002, 1'b0};
    vecs[8] = '{2'b10, 16'hFFFF, 16'h0001, 4'd15, 16'hFFFF, 1'b0};
    vecs[9] = '{2'b11, 16'h0000, 16'h0003, 4'd1,  16'h0000, 1'b0};

    Rst = 1'b1; Start = 1'b1; Op = 2'b00; OperandA = 16'h1; OperandB = 16'h1; DestReg = 4'd1;
    repeat (3) @(negedge Clk);
    check("reset outputs", {9'h0, Busy, Done, DivByZero, ResultReg, Result}, 32'h0);
    Start = 1'b0;
    Rst   = 1'b0;
    @(negedge Clk);
    check("idle after reset", {30'h0, Busy, Done}, 32'h0);

    // Directed table; alternate back-to-back and idle gaps.
    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
                    vecs[i].exp_res, vecs[i].exp_dbz, 1'b0, i % 2);
    end

    // Start while busy with new operands is ignored; then accept during Done.
    run_and_check("ignore busy start", 2'b00, 16'h00AB, 16'h0100, 4'd2, 16'hAB00, 1'b0, 1'b1, 0);
    run_and_check("back to back", 2'b10, 16'h1000, 16'h0010, 4'd12, 16'h0100, 1'b0, 1'b0, 2);

    // Reset after eight iteration edges abandons the divide.
    issue(2'b10, 16'd1000, 16'd3, 4'd5);
    for (int k = 1; k <= 9; k++) begin
      @(negedge Clk);
      if (k == 1) Start = 1'b0;
    end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort outputs", {9'h0, Busy, Done, DivByZero, ResultReg, Result}, 32'h0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0) saw_done = 1'b1;
    end
    check("abort no done", {31'h0, saw_done}, 32'h0);
    run_and_check("after abort", 2'b00, 16'd3, 16'd5, 4'd4, 16'h000F, 1'b0, 1'b0, 1);

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      rop = 2'($urandom);
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
      rd  = 4'($urandom);
      exp = ref_model(rop, ra, rb);
      run_and_check($sformatf("rand%0d", n), rop, ra, rb, rd, exp[15:0], exp[16],
                    ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
